// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR address map, bus widths and decode helper shared by the CSR file.
package csr_file_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam int MSTATUS_MIE = 3;
  function automatic logic csr_mapped(input logic [11:0] a);
`ifdef CSR_CYCLE_COUNTER_EN
    if (a == CSR_MCYCLE || a == CSR_MCYCLEH) return 1'b1;
`endif
    return a == CSR_MSTATUS || a == CSR_MIE || a == CSR_MTVEC ||
           a == CSR_MSCRATCH || a == CSR_MEPC || a == CSR_MCAUSE;
  endfunction
endpackage

// File: rtl/csr_file.sv
// csr_file: dual-write-port machine CSR file; interrupt-controller port wins same-address collisions.
// Defining CSR_CYCLE_COUNTER_EN adds the free-running mcycle/mcycleh counter.
module csr_file
  import csr_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [ADDR_W-1:0] ex_raddr,
  output logic [DATA_W-1:0] ex_rdata,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_waddr,
  input  logic [DATA_W-1:0] int_wdata,
  input  logic [ADDR_W-1:0] int_raddr,
  output logic [DATA_W-1:0] int_rdata,
  output logic [DATA_W-1:0] csr_mtvec,
  output logic [DATA_W-1:0] csr_mepc,
  output logic [DATA_W-1:0] csr_mstatus,
  output logic              global_int_en
);
  logic [DATA_W-1:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
  logic [DATA_W-1:0] mcycle, mcycleh;
  logic [11:0] ex_wa, int_wa;
  assign ex_wa  = ex_waddr[11:0];
  assign int_wa = int_waddr[11:0];
  function automatic logic [DATA_W-1:0] nxt(input logic [11:0] a, input logic [DATA_W-1:0] cur);
    return (int_we && int_wa == a) ? int_wdata : (ex_we && ex_wa == a) ? ex_wdata : cur;
  endfunction
  function automatic logic [DATA_W-1:0] rd(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:  return mstatus;
      CSR_MIE:      return mie;
      CSR_MTVEC:    return mtvec;
      CSR_MSCRATCH: return mscratch;
      CSR_MEPC:     return mepc;
      CSR_MCAUSE:   return mcause;
`ifdef CSR_CYCLE_COUNTER_EN
      CSR_MCYCLE:   return mcycle;
      CSR_MCYCLEH:  return mcycleh;
`endif
      default:      return '0;
    endcase
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mstatus  <= '0;
      mie      <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      mstatus  <= nxt(CSR_MSTATUS, mstatus);
      mie      <= nxt(CSR_MIE, mie);
      mtvec    <= nxt(CSR_MTVEC, mtvec);
      mscratch <= nxt(CSR_MSCRATCH, mscratch);
      mepc     <= nxt(CSR_MEPC, mepc);
      mcause   <= nxt(CSR_MCAUSE, mcause);
    end
`ifdef CSR_CYCLE_COUNTER_EN
  logic cyc_wr;
  assign cyc_wr = (int_we && (int_wa == CSR_MCYCLE || int_wa == CSR_MCYCLEH)) ||
                  (ex_we && (ex_wa == CSR_MCYCLE || ex_wa == CSR_MCYCLEH));
  // Any write to either half freezes the whole 32-bit count for that cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {mcycleh, mcycle} <= '0;
    else if (cyc_wr) begin
      mcycle  <= nxt(CSR_MCYCLE, mcycle);
      mcycleh <= nxt(CSR_MCYCLEH, mcycleh);
    end else {mcycleh, mcycle} <= {mcycleh, mcycle} + 32'd1;
`else
  assign mcycle  = '0;
  assign mcycleh = '0;
  logic unused_cyc;
  assign unused_cyc = ^{mcycle, mcycleh};
`endif
  logic [11:0] ex_ra;
  logic fwd_int, fwd_ex;
  assign ex_ra   = ex_raddr[11:0];
  assign fwd_int = int_we && int_wa == ex_ra && csr_mapped(ex_ra);
  assign fwd_ex  = ex_we && ex_wa == ex_ra && csr_mapped(ex_ra);
  always_comb begin
    ex_rdata  = fwd_int ? int_wdata : fwd_ex ? ex_wdata : rd(ex_ra);
    int_rdata = rd(int_raddr[11:0]);
  end
  logic [3:0] unused_hi;
  assign unused_hi     = ^{ex_waddr[15:12], int_waddr[15:12], ex_raddr[15:12], int_raddr[15:12]};
  assign csr_mtvec     = mtvec;
  assign csr_mepc      = mepc;
  assign csr_mstatus   = mstatus;
  assign global_int_en = mstatus[MSTATUS_MIE];
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed checks of csr_file writes, forwarding, collisions, reset and the cycle counter.
module tb_csr_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_we = 1'b0, int_we = 1'b0;
  logic [15:0] ex_waddr = '0, ex_wdata = '0, ex_raddr = '0;
  logic [15:0] int_waddr = '0, int_wdata = '0, int_raddr = '0;
  logic [15:0] ex_rdata, int_rdata, csr_mtvec, csr_mepc, csr_mstatus;
  logic global_int_en;
  int checks = 0;
  int failures = 0;
  csr_file dut (
    .clk(clk), .rst_n(rst_n),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_raddr(ex_raddr), .ex_rdata(ex_rdata),
    .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata), .int_raddr(int_raddr), .int_rdata(int_rdata),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .global_int_en(global_int_en)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    ex_we = 1'b0;
    int_we = 1'b0;
  endtask
  task automatic exw(input logic [15:0] a, input logic [15:0] d);
    ex_we = 1'b1; ex_waddr = a; ex_wdata = d;
  endtask
  task automatic intw(input logic [15:0] a, input logic [15:0] d);
    int_we = 1'b1; int_waddr = a; int_wdata = d;
  endtask
  initial begin
    ex_raddr = 16'h0305;
    #2;
    check("rst_mtvec", csr_mtvec, 0);
    check("rst_gie", global_int_en, 0);
    check("rst_ex_rdata", ex_rdata, 0);
    tick;
    rst_n = 1'b1;
    tick;
    exw(16'h0305, 16'h1234);
    tick;
    exw(16'h0300, 16'h0008);
    tick;
    idle;
    check("pre_rst_mtvec", csr_mtvec, 16'h1234);
    check("pre_rst_gie", global_int_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mtvec", csr_mtvec, 0);
    check("async_rst_gie", global_int_en, 0);
    check("async_rst_mstatus", csr_mstatus, 0);
    tick;
    #2 rst_n = 1'b1;
    tick;
    exw(16'h0305, 16'h0100);
    ex_raddr = 16'h0305;
    #1;
    check("ex_fwd_mtvec", ex_rdata, 16'h0100);
    check("mtvec_not_yet", csr_mtvec, 0);
    tick;
    idle;
    check("mtvec_written", csr_mtvec, 16'h0100);
    intw(16'h0341, 16'h00A0);
    exw(16'h0341, 16'h00B0);
    ex_raddr = 16'h0341;
    #1;
    check("collide_fwd", ex_rdata, 16'h00A0);
    tick;
    idle;
    check("collide_mepc", csr_mepc, 16'h00A0);
    intw(16'hA304, 16'h00AA);
    exw(16'h0340, 16'h5555);
    int_raddr = 16'h0304;
    #1;
    check("int_no_fwd", int_rdata, 0);
    tick;
    idle;
    ex_raddr = 16'h5340;
    #1;
    check("dual_mie", int_rdata, 16'h00AA);
    check("dual_mscratch", ex_rdata, 16'h5555);
    exw(16'h0300, 16'h0008);
    tick;
    idle;
    check("gie_set", global_int_en, 1);
    intw(16'h0341, 16'h0042);
    tick;
    check("seq_mepc", csr_mepc, 16'h0042);
    check("seq_gie_hold", global_int_en, 1);
    intw(16'h0300, 16'h0080);
    tick;
    check("seq_mstatus", csr_mstatus, 16'h0080);
    check("seq_gie_fall", global_int_en, 0);
    intw(16'h0342, 16'h0004);
    int_raddr = 16'h0342;
    #1;
    check("seq_mcause_old", int_rdata, 0);
    tick;
    idle;
    check("seq_mcause", int_rdata, 16'h0004);
    exw(16'h07C0, 16'hFFFF);
    ex_raddr = 16'h07C0;
    #1;
    check("unmapped_fwd", ex_rdata, 0);
    tick;
    idle;
    check("unmapped_rd", ex_rdata, 0);
    check("unmapped_mtvec", csr_mtvec, 16'h0100);
    check("unmapped_mepc", csr_mepc, 16'h0042);
    check("unmapped_mstatus", csr_mstatus, 16'h0080);
    intw(16'h0B00, 16'hFFFE);
    exw(16'h0B80, 16'h0003);
    ex_raddr = 16'h0B00;
    int_raddr = 16'h0B80;
    tick;
    idle;
`ifdef CSR_CYCLE_COUNTER_EN
    check("cyc_preset_lo", ex_rdata, 16'hFFFE);
    check("cyc_preset_hi", int_rdata, 16'h0003);
    tick;
    check("cyc_step_lo", ex_rdata, 16'hFFFF);
    check("cyc_step_hi", int_rdata, 16'h0003);
    tick;
    check("cyc_carry_lo", ex_rdata, 0);
    check("cyc_carry_hi", int_rdata, 16'h0004);
`else
    check("cyc_off_lo", ex_rdata, 0);
    check("cyc_off_hi", int_rdata, 0);
    tick;
    check("cyc_off_lo2", ex_rdata, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports (EX port): ex_we input 1 write strobe; ex_waddr input 16 write address; ex_wdata input 16 write data; ex_raddr input 16 read address; ex_rdata output 16 read data.
REQ-004 SHALL have ports (interrupt-controller port): int_we input 1; int_waddr input 16; int_wdata input 16; int_raddr input 16; int_rdata output 16.
REQ-005 SHALL have ports: csr_mtvec output 16; csr_mepc output 16; csr_mstatus output 16; global_int_en output 1.
REQ-006 SHALL use parameter-free addressing: CSR address = addr[11:0]; addr[15:12] ignored.

Function
REQ-007 SHALL implement 16-bit registers: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
REQ-008 SHALL update each register one cycle after its write strobe is sampled high at its address.
REQ-009 SHALL accept both write ports in the same cycle when addresses differ.
REQ-010 SHALL give the interrupt-controller port priority when both ports write the same address in the same cycle; the EX write is dropped.
REQ-011 SHALL ignore writes to unmapped addresses; reads of unmapped addresses SHALL return 16'h0000.
REQ-012 SHALL drive ex_rdata and int_rdata combinationally from the addressed register.
REQ-013 SHALL forward write data to ex_rdata when ex_raddr matches an active write in the same cycle (int_wdata wins over ex_wdata per REQ-010); int_rdata SHALL return the registered value, without forwarding.
REQ-014 SHALL drive csr_mtvec, csr_mepc and csr_mstatus directly from the registers, without forwarding.
REQ-015 SHALL drive global_int_en = mstatus[3] (MIE), registered value.
REQ-016 SHALL treat all 16 bits of every mapped register as read/write.

Reset
REQ-017 SHALL clear every register to 16'h0000 on rst_n low, asynchronously, without waiting for clk.
REQ-018 SHALL hold global_int_en = 0 and all outputs at 16'h0000 while in reset (rdata outputs reflect address decode of zeroed registers).
REQ-019 SHALL resume normal operation on the first rising clk after rst_n deasserts; reset mid-write discards that write.

Configuration
REQ-020 SHALL, with macro CSR_CYCLE_COUNTER_EN defined, add mcycle (0xB00) and mcycleh (0xB80), both 16-bit, reset 0.
REQ-021 SHALL, with the macro defined, increment {mcycleh,mcycle} by 1 every cycle; a carry from mcycle 16'hFFFF SHALL increment mcycleh; 32-bit value wraps to 0.
REQ-022 SHALL, with the macro defined, let a write to mcycle or mcycleh replace that half that cycle, suppressing the increment for both halves in that cycle.
REQ-023 SHALL, without the macro, treat 0xB00/0xB80 as unmapped (REQ-011).

Structure
REQ-024 SHALL take CSR address constants (CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH), 12 bits each, and the data/address bus widths from the shared parameter include file.
REQ-025 SHALL be a single module; the cycle counter SHALL NOT be a separate sub-module.

Verification
REQ-026 Reset: rst_n low mid-cycle with mtvec=16'h1234 -> csr_mtvec=0 immediately; global_int_en=0.
REQ-027 EX write: ex_we=1, addr 0x305, data 16'h0100 -> csr_mtvec=16'h0100 next cycle; ex_rdata@0x305 same cycle=16'h0100 (forwarded).
REQ-028 Collision: both ports write 0x341, int 16'h00A0, ex 16'h00B0 -> mepc=16'h00A0; ex_rdata@0x341 in that cycle=16'h00A0.
REQ-029 Interrupt sequence: int writes mepc=16'h0042, mstatus=16'h0080, mcause=16'h0004 on consecutive cycles -> each visible one cycle later; global_int_en falls from 1 to 0 on the mstatus write.
REQ-030 Unmapped: ex write 0x7C0 data 16'hFFFF -> no register changes; ex_rdata@0x7C0=0.
REQ-031 Counter (macro on): preset mcycle=16'hFFFE, mcycleh=16'h0003 -> after 2 cycles mcycle=0, mcycleh=16'h0004; macro off -> reads return 0.
